btn_debounce: RTL and testbench
===============================

// Module: btn_debounce
// PURPOSE
//  Debounces N_BTN asynchronous push-buttons using the 1 kHz tick from tick_gen.
//  It sits between the board pins and the user-control logic.
//  Per button it outputs a clean level plus one-clk pulses for press, release,
//  long-press and auto-repeat.
//  Every timing value is counted in ticks (ms at 1 kHz), never in raw clk cycles.
// PARAMETERS
//  N_BTN        4     number of independent button channels
//  DEBOUNCE_MS  20    ticks input must stay stable to accept a change (>=1)
//  LONG_MS      1000  ticks held (after accepted press) before long pulse (>=2)
//  REPEAT_MS    200   ticks between repeat pulses after long pulse (>=1)
//  REPEAT_EN    1     1 = generate repeat pulses; 0 = repeat output tied 0
// PORTS
//  clk      in   1      system clock (100 MHz)
//  rst      in   1      reset, synchronous, active-high
//  tick     in   1      1-clk strobe at 1 kHz from tick_gen
//  btn_in   in   N_BTN  raw asynchronous button pins, 1 = pressed
//  level    out  N_BTN  debounced state, 1 = pressed
//  press    out  N_BTN  1-clk pulse on accepted press
//  release  out  N_BTN  1-clk pulse on accepted release
//  long_p   out  N_BTN  1-clk pulse once per hold, at LONG_MS
//  repeat_p out  N_BTN  1-clk pulse every REPEAT_MS after long_p while held
// BEHAVIOUR
//  Reset: reset is clk rst, synchronous, active-high. All synchronizer flops,
//    states, counters and outputs go to 0 / UP. A reset mid-hold emits no
//    release pulse.
//  Sync: 2-flop synchronizer per channel; s = 2nd stage. FSM sees only s.
//  Per-channel FSM states: UP, DN_PEND, DOWN, UP_PEND.
//    Debounce counter dcnt uses $clog2(DEBOUNCE_MS+1) bits.
//    Hold counter hcnt is sized for max(LONG_MS, REPEAT_MS).
//    A phase flag lp is set after long_p.
//  UP:      s=1 -> DN_PEND, dcnt=0.
//  DN_PEND: s=0 -> UP (bounce rejected, no output).
//           Else, on a tick: if dcnt==DEBOUNCE_MS-1 -> DOWN, level<=1, press
//           pulse, hcnt=0, lp=0; otherwise dcnt++.
//  DOWN:    s=0 -> UP_PEND, dcnt=0, hcnt frozen.
//           Else, on a tick:
//             lp=0 and hcnt==LONG_MS-1 -> long_p pulse, lp=1, hcnt=0.
//             lp=1, REPEAT_EN=1, hcnt==REPEAT_MS-1 -> repeat_p pulse, hcnt=0.
//             otherwise hcnt++ (saturates at max value if REPEAT_EN=0).
//  UP_PEND: s=1 -> DOWN (hold resumes; hcnt and lp retained).
//           Else, on a tick: if dcnt==DEBOUNCE_MS-1 -> UP, level<=0, release
//           pulse; otherwise dcnt++.
//  Change of s vs. tick in the same clk: the change of s wins (pending state is
//    abandoned / counter restarted); that tick is not counted.
//  Latency: an accepted change registers on the clk after the qualifying tick.
//    Pin to level is 2 sync clks + DEBOUNCE_MS ticks (first tick may be partial).
//  Pulses are exactly 1 clk wide. At most one of press/release/long_p/repeat_p
//    fires per channel per clk. Channels are fully independent.
//  tick held high for consecutive clks counts once per clk; tick_gen guarantees
//    a 1-clk strobe.
// TESTING (bench params: DEBOUNCE_MS=4, LONG_MS=10, REPEAT_MS=3; tick every 10 clk)
//  1 btn_in[0]=1 held -> press[0] pulse once, level[0]=1 after the 4th tick
//    following sync; no other channel toggles.
//  2 btn_in[1] bounces 1/0 every 15 clk for 200 clk, then stays 0
//    -> no press[1], level[1] stays 0.
//  3 btn_in[2] held 20 ticks -> long_p at hold tick 10; repeat_p at ticks 13,
//    16, 19; release after 4 ticks once released.
//  4 Held button glitches low for 2 ticks -> no release; hcnt resumes and
//    long_p timing shifts by the frozen span only.
//  5 rst asserted for 1 clk while level[3]=1 -> all outputs 0 the next clk,
//    no release pulse; a fresh press is accepted normally afterwards.
//  6 REPEAT_EN=0, button held 30 ticks -> exactly one long_p, zero repeat_p.

Source files
------------

// File: rtl/btn_debounce.sv
// Per-channel push-button debouncer: 2-flop synchronizer plus a tick-timed FSM that produces a
// clean level and one-clk press / release / long-press / auto-repeat pulses.
module btn_debounce #(
    parameter int unsigned N_BTN       = 4,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000,
    parameter int unsigned REPEAT_MS   = 200,
    parameter int unsigned REPEAT_EN   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press,
    // "release" is a reserved word, hence the _p suffix like its sibling pulses
    output logic [N_BTN-1:0] release_p,
    output logic [N_BTN-1:0] long_p,
    output logic [N_BTN-1:0] repeat_p
);

    localparam int unsigned HOLD_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
    localparam int unsigned DW       = $clog2(DEBOUNCE_MS + 1);
    localparam int unsigned HW       = $clog2(HOLD_MAX + 1);

    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_MS - 1);
    localparam logic [HW-1:0] L_LAST = HW'(LONG_MS - 1);
    localparam logic [HW-1:0] R_LAST = HW'(REPEAT_MS - 1);
    localparam logic [HW-1:0] H_SAT  = '1;

    typedef enum logic [1:0] {StUp, StDnPend, StDown, StUpPend} state_e;

    logic [N_BTN-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        state_e        st_q, st_d;
        logic [DW-1:0] dcnt_q, dcnt_d;
        logic [HW-1:0] hcnt_q, hcnt_d;
        logic          lp_q, lp_d;
        logic          level_q, level_d;
        logic          press_q, press_d;
        logic          rel_q, rel_d;
        logic          long_q, long_d;
        logic          rep_q, rep_d;
        logic          s;

        assign s = sync2_q[i];

        // A change of s always takes priority over a coincident tick.
        always_comb begin
            st_d    = st_q;
            dcnt_d  = dcnt_q;
            hcnt_d  = hcnt_q;
            lp_d    = lp_q;
            level_d = level_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            long_d  = 1'b0;
            rep_d   = 1'b0;
            unique case (st_q)
                StUp: begin
                    if (s) begin
                        st_d   = StDnPend;
                        dcnt_d = '0;
                    end
                end
                StDnPend: begin
                    if (!s) begin
                        st_d = StUp;
                    end else if (tick) begin
                        if (dcnt_q == D_LAST) begin
                            st_d    = StDown;
                            level_d = 1'b1;
                            press_d = 1'b1;
                            hcnt_d  = '0;
                            lp_d    = 1'b0;
                        end else begin
                            dcnt_d = dcnt_q + 1'b1;
                        end
                    end
                end
                StDown: begin
                    if (!s) begin
                        st_d   = StUpPend;
                        dcnt_d = '0;
                    end else if (tick) begin
                        if (!lp_q && hcnt_q == L_LAST) begin
                            long_d = 1'b1;
                            lp_d   = 1'b1;
                            hcnt_d = '0;
                        end else if (lp_q && REPEAT_EN != 0 && hcnt_q == R_LAST) begin
                            rep_d  = 1'b1;
                            hcnt_d = '0;
                        end else if (hcnt_q != H_SAT) begin
                            hcnt_d = hcnt_q + 1'b1;
                        end
                    end
                end
                StUpPend: begin
                    if (s) begin
                        st_d = StDown;
                    end else if (tick) begin
                        if (dcnt_q == D_LAST) begin
                            st_d    = StUp;
                            level_d = 1'b0;
                            rel_d   = 1'b1;
                        end else begin
                            dcnt_d = dcnt_q + 1'b1;
                        end
                    end
                end
                default: st_d = StUp;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                st_q    <= StUp;
                dcnt_q  <= '0;
                hcnt_q  <= '0;
                lp_q    <= 1'b0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
                rep_q   <= 1'b0;
            end else begin
                st_q    <= st_d;
                dcnt_q  <= dcnt_d;
                hcnt_q  <= hcnt_d;
                lp_q    <= lp_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                long_q  <= long_d;
                rep_q   <= rep_d;
            end
        end

        assign level[i]     = level_q;
        assign press[i]     = press_q;
        assign release_p[i] = rel_q;
        assign long_p[i]    = long_q;
        assign repeat_p[i]  = rep_q;
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: one instance with auto-repeat, one without, sharing stimulus.
module tb_btn_debounce;

    localparam int N = 4;

    logic         clk    = 1'b0;
    logic         rst    = 1'b1;
    logic         tick   = 1'b0;
    logic [N-1:0] btn_in = '0;

    logic [N-1:0] level, press, release_p, long_p, repeat_p;
    logic [N-1:0] b_level, b_press, b_release, b_long, b_repeat;

    always #5 clk = ~clk;

    btn_debounce #(
        .N_BTN(N), .DEBOUNCE_MS(4), .LONG_MS(10), .REPEAT_MS(3), .REPEAT_EN(1)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .btn_in(btn_in),
        .level(level), .press(press), .release_p(release_p),
        .long_p(long_p), .repeat_p(repeat_p)
    );

    btn_debounce #(
        .N_BTN(N), .DEBOUNCE_MS(4), .LONG_MS(10), .REPEAT_MS(3), .REPEAT_EN(0)
    ) dut_norep (
        .clk(clk), .rst(rst), .tick(tick), .btn_in(btn_in),
        .level(b_level), .press(b_press), .release_p(b_release),
        .long_p(b_long), .repeat_p(b_repeat)
    );

    int n_press[N], n_rel[N], n_long[N], n_rep[N];
    int press_tick[N], rel_tick[N], long_tick[N];
    int rep_tick[N][8];
    int nb_long[N], nb_rep[N];
    int nb_rep_ever, multi;
    int tcnt, cyc, n_cmp, n_bad, t0;
    bit last_tick;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // One clk: sample outputs on the falling edge, then drive the next tick value.
    task automatic cycle();
        @(negedge clk);
        last_tick = tick;
        if (tick) tcnt++;
        for (int c = 0; c < N; c++) begin
            if (press[c]) begin n_press[c]++; press_tick[c] = tcnt; end
            if (release_p[c]) begin n_rel[c]++; rel_tick[c] = tcnt; end
            if (long_p[c]) begin n_long[c]++; long_tick[c] = tcnt; end
            if (repeat_p[c]) begin
                if (n_rep[c] < 8) rep_tick[c][n_rep[c]] = tcnt;
                n_rep[c]++;
            end
            if ($countones({press[c], release_p[c], long_p[c], repeat_p[c]}) > 1) multi++;
            if (b_long[c]) nb_long[c]++;
            if (b_repeat[c]) begin nb_rep[c]++; nb_rep_ever++; end
        end
        cyc++;
        tick = (cyc % 10 == 0);
    endtask

    task automatic to_tick();
        int g = 0;
        do begin
            cycle();
            g++;
        end while (!last_tick && g < 50);
        if (!last_tick) chk("tick_timeout", 0, 1);
    endtask

    task automatic ticks(input int n);
        repeat (n) to_tick();
    endtask

    task automatic clear();
        for (int c = 0; c < N; c++) begin
            n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0; n_rep[c] = 0;
            nb_long[c] = 0; nb_rep[c] = 0;
        end
    endtask

    initial begin
        repeat (3) cycle();
        chk("reset_outs", int'({level, press, release_p, long_p, repeat_p}), 0);
        chk("reset_outs_norep", int'({b_level, b_press, b_release, b_long, b_repeat}), 0);
        rst = 1'b0;
        clear();

        // 1: clean press on channel 0
        to_tick();
        t0 = tcnt;
        btn_in[0] = 1'b1;
        ticks(3);
        chk("t1_level_pre", int'(level[0]), 0);
        to_tick();
        chk("t1_level", int'(level[0]), 1);
        chk("t1_press_cnt", n_press[0], 1);
        chk("t1_press_tick", press_tick[0] - t0, 4);
        chk("t1_others", int'(level[3:1]) + n_press[1] + n_press[2] + n_press[3], 0);
        btn_in[0] = 1'b0;
        ticks(6);
        chk("t1_release_cnt", n_rel[0], 1);

        // 2: bouncing channel 1 never accepted
        clear();
        for (int k = 0; k < 200; k++) begin
            if (k % 15 == 0) btn_in[1] = ~btn_in[1];
            cycle();
            if (k == 100) chk("t2_level_mid", int'(level[1]), 0);
        end
        btn_in[1] = 1'b0;
        ticks(6);
        chk("t2_press_cnt", n_press[1], 0);
        chk("t2_level", int'(level[1]), 0);

        // 3: long hold with repeats on channel 2
        clear();
        to_tick();
        t0 = tcnt;
        btn_in[2] = 1'b1;
        ticks(24);
        chk("t3_long_cnt", n_long[2], 1);
        chk("t3_long_tick", long_tick[2] - t0, 14);
        chk("t3_rep_cnt", n_rep[2], 3);
        chk("t3_rep0", rep_tick[2][0] - t0, 17);
        chk("t3_rep1", rep_tick[2][1] - t0, 20);
        chk("t3_rep2", rep_tick[2][2] - t0, 23);
        btn_in[2] = 1'b0;
        ticks(4);
        chk("t3_rel_cnt", n_rel[2], 1);
        chk("t3_rel_tick", rel_tick[2] - t0, 28);
        chk("t3_level", int'(level[2]), 0);
        chk("t3_rep_after", n_rep[2], 3);

        // 4: 2-tick low glitch during hold freezes the hold counter
        clear();
        to_tick();
        t0 = tcnt;
        btn_in[2] = 1'b1;
        ticks(7);
        btn_in[2] = 1'b0;
        ticks(2);
        chk("t4_level_glitch", int'(level[2]), 1);
        btn_in[2] = 1'b1;
        ticks(7);
        chk("t4_long_cnt", n_long[2], 1);
        chk("t4_long_tick", long_tick[2] - t0, 16);
        chk("t4_no_release", n_rel[2], 0);
        btn_in[2] = 1'b0;
        ticks(6);
        chk("t4_release_cnt", n_rel[2], 1);

        // 5: reset mid-hold on channel 3
        clear();
        to_tick();
        btn_in[3] = 1'b1;
        ticks(4);
        chk("t5_level_pre", int'(level[3]), 1);
        ticks(2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t5_outs_after_rst", int'({level, press, release_p, long_p, repeat_p}), 0);
        chk("t5_no_release", n_rel[3], 0);
        ticks(3);
        chk("t5_level_wait", int'(level[3]), 0);
        to_tick();
        chk("t5_level_fresh", int'(level[3]), 1);
        chk("t5_press_cnt", n_press[3], 2);
        chk("t5_no_release2", n_rel[3], 0);
        btn_in[3] = 1'b0;
        ticks(6);

        // 6: 30-tick hold, with and without auto-repeat
        clear();
        to_tick();
        btn_in[1] = 1'b1;
        ticks(34);
        chk("t6_norep_long", nb_long[1], 1);
        chk("t6_norep_rep", nb_rep[1], 0);
        chk("t6_rep_long", n_long[1], 1);
        chk("t6_rep_cnt", n_rep[1], 6);
        btn_in[1] = 1'b0;
        ticks(6);
        chk("t6_level", int'(level[1]), 0);

        chk("norep_never_repeats", nb_rep_ever, 0);
        chk("one_pulse_per_clk", multi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
